// File: rtl/gray_area_package.sv
// Shared Hamming helpers and the error-class encoding for the
// streaming SECDED decoder.
package gray_area_package;

  typedef enum logic [1:0] {
    HAM_OK,
    HAM_SINGLE,
    HAM_DOUBLE,
    HAM_UNCORR
  } ham_err_e;

  // Smallest r such that 2^r covers data, parity and position 0.
  function automatic int hamming_address_width(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++)
      if (r == 0 && (1 << i) >= dw + i + 1)
        r = i;
    return r;
  endfunction

  function automatic int hamming_coded_width(input int dw);
    return dw + hamming_address_width(dw) + 1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall parity of a Hamming codeword;
// shared between the decoder and the encoder check path.
module hamming_syndrome #(
  parameter int CODED_WIDTH = 39,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic [CODED_WIDTH-1:0] i_code,
  output logic [ADDR_WIDTH-1:0]  o_syndrome,
  output logic                   o_parity
);

  always_comb begin
    o_syndrome = '0;
    for (int i = 1; i < CODED_WIDTH; i++)
      if (i_code[i])
        o_syndrome = o_syndrome ^ ADDR_WIDTH'(i);
  end

  assign o_parity = ^i_code;

endmodule

// File: rtl/hamming_decode_pipe.sv
// Two-stage streaming SECDED decoder with optional single-bit
// correction, saturating error counters and last-fault capture.
module hamming_decode_pipe
  import gray_area_package::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  CNT_WIDTH   = 16,
  localparam int ADDR_WIDTH  = hamming_address_width(DATA_WIDTH),
  localparam int CODED_WIDTH = hamming_coded_width(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   correct_en_i,
  input  logic                   clr_cnt_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CODED_WIDTH-1:0] data_in_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  data_out_o,
  output logic [CODED_WIDTH-1:0] raw_data_o,
  output logic [1:0]             num_errors_o,
  output logic [ADDR_WIDTH-1:0]  fault_location_o,
  output logic [CNT_WIDTH-1:0]   corr_count_o,
  output logic [CNT_WIDTH-1:0]   uncorr_count_o,
  output logic [ADDR_WIDTH-1:0]  last_fault_loc_o,
  output logic                   last_fault_vld_o
);

  logic                   r_s1_vld;
  logic [CODED_WIDTH-1:0] r_s1_code;
  logic [ADDR_WIDTH-1:0]  r_s1_syn;
  logic                   r_s1_par;
  logic                   r_s1_cen;

  logic                   r_s2_vld;
  ham_err_e               r_s2_cls;
  logic [DATA_WIDTH-1:0]  r_s2_data;
  logic [CODED_WIDTH-1:0] r_s2_raw;
  logic [ADDR_WIDTH-1:0]  r_s2_loc;

  logic [CNT_WIDTH-1:0]   r_corr;
  logic [CNT_WIDTH-1:0]   r_uncorr;
  logic [ADDR_WIDTH-1:0]  r_last_loc;
  logic                   r_last_vld;

  logic [ADDR_WIDTH-1:0]  w_syn;
  logic                   w_par;
  logic                   w_adv;
  logic                   w_xfer;
  logic                   w_syn_zero;
  logic                   w_in_range;
  ham_err_e               w_cls;
  logic [CODED_WIDTH-1:0] w_flip;
  logic [CODED_WIDTH-1:0] w_fixed;
  logic [DATA_WIDTH-1:0]  w_data;

  hamming_syndrome #(
    .CODED_WIDTH (CODED_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_syn (
    .i_code     (data_in_i),
    .o_syndrome (w_syn),
    .o_parity   (w_par)
  );

  assign w_adv  = !r_s2_vld || out_ready_i;
  assign w_xfer = r_s2_vld && out_ready_i;

  assign w_syn_zero = (r_s1_syn == '0);
  assign w_in_range = int'(r_s1_syn) < CODED_WIDTH;

  always_comb begin
    w_cls = HAM_OK;
    unique case (1'b1)
      (w_syn_zero && !r_s1_par):               w_cls = HAM_OK;
      (w_syn_zero && r_s1_par):                w_cls = HAM_SINGLE;
      (!w_syn_zero && !r_s1_par):              w_cls = HAM_DOUBLE;
      (!w_syn_zero && r_s1_par && w_in_range): w_cls = HAM_SINGLE;
      (!w_syn_zero && r_s1_par && !w_in_range): w_cls = HAM_UNCORR;
    endcase
  end

  // Syndrome 0 flips only the overall parity bit, leaving the payload intact.
  assign w_flip  = (w_cls == HAM_SINGLE && r_s1_cen) ?
                   (CODED_WIDTH'(1) << r_s1_syn) : '0;
  assign w_fixed = r_s1_code ^ w_flip;

  for (genvar k = 1; k < ADDR_WIDTH; k++) begin : g_seg
    localparam int LO  = (1 << k) + 1;
    localparam int TOP = (1 << (k + 1)) - 1;
    localparam int HI  = (TOP < CODED_WIDTH - 1) ? TOP : CODED_WIDTH - 1;
    localparam int OFF = (1 << k) - k - 1;
    if (HI >= LO) begin : g_map
      assign w_data[OFF +: HI-LO+1] = w_fixed[HI:LO];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_code <= '0;
      r_s1_syn  <= '0;
      r_s1_par  <= 1'b0;
      r_s1_cen  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_cls  <= HAM_OK;
      r_s2_data <= '0;
      r_s2_raw  <= '0;
      r_s2_loc  <= '0;
    end else if (w_adv) begin
      r_s1_vld <= in_valid_i;
      if (in_valid_i) begin
        r_s1_code <= data_in_i;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
        r_s1_cen  <= correct_en_i;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_cls  <= w_cls;
        r_s2_data <= w_data;
        r_s2_raw  <= r_s1_code;
        r_s2_loc  <= r_s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt_i) begin
      r_corr     <= '0;
      r_uncorr   <= '0;
      r_last_loc <= '0;
      r_last_vld <= 1'b0;
    end else if (w_xfer) begin
      if (r_s2_cls == HAM_SINGLE && r_corr != '1)
        r_corr <= r_corr + CNT_WIDTH'(1);
      if ((r_s2_cls == HAM_DOUBLE || r_s2_cls == HAM_UNCORR)
          && r_uncorr != '1)
        r_uncorr <= r_uncorr + CNT_WIDTH'(1);
      if (r_s2_cls != HAM_OK) begin
        r_last_loc <= r_s2_loc;
        r_last_vld <= 1'b1;
      end
    end
  end

  assign in_ready_o       = w_adv;
  assign out_valid_o      = r_s2_vld;
  assign data_out_o       = r_s2_data;
  assign raw_data_o       = r_s2_raw;
  assign num_errors_o     = r_s2_cls;
  assign fault_location_o = r_s2_loc;
  assign corr_count_o     = r_corr;
  assign uncorr_count_o   = r_uncorr;
  assign last_fault_loc_o = r_last_loc;
  assign last_fault_vld_o = r_last_vld;

endmodule
